// File: rtl/bus_alu_sequencer_pkg.sv
// Shared opcode/state definitions for the single-bus ALU sequencer.
// Imported by the top level and the ALU.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_T_RB  = 3'd1;
  localparam logic [2:0] S_T_RC  = 3'd2;
  localparam logic [2:0] S_T_ZLO = 3'd3;
  localparam logic [2:0] S_T_ZHI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/bus_alu_sequencer_if.sv
// Control-side bundle of the ALU sequencer: issue, external load,
// debug read and status.
interface bus_alu_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              start;
  logic [3:0]        op;
  logic [IDX_W-1:0]  ra;
  logic [IDX_W-1:0]  rb;
  logic [IDX_W-1:0]  rc;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic [DATA_W-1:0] bus_dbg;

  modport master (
    output start, op, ra, rb, rc,
    output wr_en, wr_idx, wr_data, rd_idx,
    input  rd_data, busy, done, err,
    input  hi_out, lo_out, bus_dbg
  );

  modport slave (
    input  start, op, ra, rb, rc,
    input  wr_en, wr_idx, wr_data, rd_idx,
    output rd_data, busy, done, err,
    output hi_out, lo_out, bus_dbg
  );
endinterface

// File: rtl/bus_alu_sequencer_alu.sv
// Combinational ALU: a comes from Y, b from the bus.
// Illegal opcodes produce a zero result.
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [3:0]          op,
  output logic [2*DATA_W-1:0] result
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   lo_w;
  logic [2*DATA_W-1:0] prod;

  assign sh = b[SH_W-1:0];

  // Sign-extend to full width so the product keeps all 2*DATA_W bits
  assign prod = $signed({{DATA_W{a[DATA_W-1]}}, a})
              * $signed({{DATA_W{b[DATA_W-1]}}, b});

  always_comb begin
    lo_w = '0;
    unique case (op)
      OP_ADD:  lo_w = a + b;
      OP_SUB:  lo_w = a - b;
      OP_AND:  lo_w = a & b;
      OP_OR:   lo_w = a | b;
      OP_SHL:  lo_w = a << sh;
      OP_SHR:  lo_w = a >> sh;
      OP_SHRA: lo_w = $signed(a) >>> sh;
      OP_NOT:  lo_w = ~b;
      default: lo_w = '0;
    endcase
  end

  always_comb begin
    result = {{DATA_W{1'b0}}, lo_w};
    if (op == OP_MUL) result = prod;
  end

endmodule

// File: rtl/bus_alu_sequencer.sv
// Single-bus datapath running R[ra] <= R[rb] op R[rc] as a
// T-state sequence through Y and {ZHI,ZLO}.
module bus_alu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic               clk,
  input logic               clr,
  bus_alu_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y, zhi, zlo, hi, lo;
  logic [DATA_W-1:0]   bus_v;
  logic [2*DATA_W-1:0] alu_res;
  logic [2:0]          state;
  logic [3:0]          op_q;
  logic [IDX_W-1:0]    ra_q, rb_q, rc_q;
  logic                done_q, err_q;
  logic                legal, is_mul;

  assign legal  = is_legal_op(op_q);
  assign is_mul = op_q == OP_MUL;

  always_comb begin
    bus_v = '0;
    unique case (1'b1)
      (state == S_T_RB):  bus_v = regs[rb_q];
      (state == S_T_RC):  bus_v = regs[rc_q];
      (state == S_T_ZLO): bus_v = zlo;
      (state == S_T_ZHI): bus_v = zhi;
      default:            bus_v = '0;
    endcase
  end

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .a      (y),
    .b      (bus_v),
    .op     (op_q),
    .result (alu_res)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      y      <= '0;
      zhi    <= '0;
      zlo    <= '0;
      hi     <= '0;
      lo     <= '0;
      state  <= S_IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.wr_en) regs[bus.wr_idx] <= bus.wr_data;
          if (bus.start) begin
            op_q  <= bus.op;
            ra_q  <= bus.ra;
            rb_q  <= bus.rb;
            rc_q  <= bus.rc;
            state <= S_T_RB;
          end
        end
        S_T_RB: begin
          y     <= bus_v;
          state <= S_T_RC;
        end
        S_T_RC: begin
          {zhi, zlo} <= alu_res;
          state      <= S_T_ZLO;
        end
        S_T_ZLO: begin
          if (legal) regs[ra_q] <= bus_v;
          if (is_mul) begin
            lo    <= bus_v;
            state <= S_T_ZHI;
          end else begin
            state  <= S_DONE;
            done_q <= 1'b1;
            err_q  <= ~legal;
          end
        end
        S_T_ZHI: begin
          hi     <= bus_v;
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data = regs[bus.rd_idx];
  assign bus.busy    = state != S_IDLE;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.hi_out  = hi;
  assign bus.lo_out  = lo;
  assign bus.bus_dbg = bus_v;

endmodule

// File: doc/bus_alu_sequencer.md
Name: bus_alu_sequencer

Overview:
- Parametrised successor to the single-bus CPU datapath. Holds a NUM_REGS x DATA_W general register file, Y, Z (ZHI/ZLO), HI and LO registers on one shared internal bus.
- Runs a complete three-register ALU instruction (R[ra] <= R[rb] op R[rc]) as a multi-cycle T-state sequence.
- Intended to sit under the future control unit. The control unit issues start/op/indices and waits for done.

Parameters:
- DATA_W, 32, datapath width; power of two, >= 8
- NUM_REGS, 16, number of general registers; power of two, >= 2
- IDX_W, $clog2(NUM_REGS), register index width; localparam, not overridable

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  begin instruction; sampled only in IDLE
- op  in  4  ALU opcode
- ra  in  IDX_W  destination register index
- rb  in  IDX_W  first source register index (via Y)
- rc  in  IDX_W  second source register index (direct from bus)
- wr_en  in  1  external register load; honoured only in IDLE
- wr_idx  in  IDX_W  external load index
- wr_data  in  DATA_W  external load value
- rd_idx  in  IDX_W  debug read index
- rd_data  out  DATA_W  R[rd_idx], combinational
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; high if op was illegal
- hi_out  out  DATA_W  HI register
- lo_out  out  DATA_W  LO register
- bus_dbg  out  DATA_W  current internal bus value

Behaviour:
- Reset: on clr, all registers (R, Y, ZHI, ZLO, HI, LO) go to 0, state goes to IDLE, and busy/done/err go to 0. A clr in mid-operation aborts with no writeback and no done pulse.
- Bus: exactly one source per state. IDLE: 0. T_RB: R[rb]. T_RC: R[rc]. T_ZLO: ZLO. T_ZHI: ZHI. DONE: 0.
- States and transitions:
  - IDLE: if start, latch op, ra, rb, rc -> T_RB.
  - T_RB: Y <= bus -> T_RC.
  - T_RC: {ZHI,ZLO} <= alu(Y, bus) -> T_ZLO.
  - T_ZLO: if op legal and not MUL, R[ra] <= bus. If MUL, LO <= bus and R[ra] <= bus. Next state: -> T_ZHI if MUL, else -> DONE.
  - T_ZHI: HI <= bus -> DONE.
  - DONE: done = 1, err = illegal flag -> IDLE.
- Latency: with start high in cycle 0, done is high in cycle 4 for non-MUL ops and cycle 5 for MUL. Back-to-back issue is possible: start may be high in the DONE cycle's following IDLE cycle. Throughput is 1 op per 5 cycles (6 for MUL).
- start while busy: ignored, not queued.
- wr_en while busy: ignored.
- wr_en and start in the same IDLE cycle: the write commits at that edge, and the op reads the new value.
- Aliasing: ra, rb and rc may alias, since sources are read in distinct cycles.
- ALU opcodes, result into {ZHI,ZLO}, with ZHI = 0 unless noted:
  - 0 ADD and 1 SUB: modulo 2^DATA_W.
  - 2 AND, 3 OR.
  - 4 SHL, 5 SHR (logical), 6 SHRA (arithmetic): shift Y by bus[$clog2(DATA_W)-1:0].
  - 7 MUL: signed, full 2*DATA_W product.
  - 8 NOT: ~bus, Y ignored.
- Illegal opcodes (9-15): the sequence still runs, but Z is loaded with 0, no register/HI/LO write occurs, and err = 1 with done.
- done and err are registered outputs; err is 0 whenever done is 0.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (OP_ADD..OP_NOT), state encoding (S_IDLE, S_T_RB, S_T_RC, S_T_ZLO, S_T_ZHI, S_DONE), and an is_legal_op function.
- One sub-module, alu_param (DATA_W): purely combinational, inputs a, b, op; output 2*DATA_W result. The register file and FSM stay in the top level.

Test Plan:
- Load R1=5 and R2=7 via wr_en, then start ADD ra=3 rb=1 rc=2 -> done in cycle 4, err=0, R3=12, HI/LO unchanged at 0.
- R1=0xFFFFFFFE and R2=3, start MUL ra=4 -> done in cycle 5, R4=LO=0xFFFFFFFA, HI=0xFFFFFFFF.
- R1=0x80000000 and R2=4:
  - SHRA ra=5 -> R5=0xF8000000.
  - then SHR ra=6 -> R6=0x08000000.
  - Second start issued in the cycle after done -> second done 5 cycles after the first.
- start with op=12 -> done with err=1, and no register changes (all R compared before and after).
- Assert clr during T_RC of an ADD -> the next cycle shows busy=0 and all registers 0, with no done pulse.
- During an op, pulse start (different op) and wr_en (R7=0x55) while busy -> both ignored: R7 unchanged, single done. Also ADD ra=rb=rc=1 with R1=9 -> R1=18.
